// File: rtl/share_load_pkg.sv
// Shared types and helpers for the share-register load controller.
// Optional CLEAR phase is enabled by defining SHARE_LOAD_CLEAR_EN.
package share_load_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    CLEAR = 2'd3
  } share_load_state_t;

  function automatic int idx_w(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/share_load_idx_cnt.sv
// Share index counter: increments on each accepted share, wraps after D-1.
module share_load_idx_cnt #(
  parameter int D     = 2,
  parameter int IDX_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_at_last
);

  logic [IDX_W-1:0] r_idx;

  assign o_idx     = r_idx;
  assign o_at_last = (r_idx == IDX_W'(D - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_idx <= '0;
    else if (i_inc)   r_idx <= o_at_last ? '0 : r_idx + IDX_W'(1);
  end

endmodule

// File: rtl/share_load_ctrl.sv
// Sequences D share-register enables, gated by fresh randomness, and hands the
// full sharing downstream. Define SHARE_LOAD_CLEAR_EN to zero the bank after each consume.
module share_load_ctrl
  import share_load_pkg::*;
#(
  parameter int D = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic         i_in_last,
  input  logic         i_rnd_valid,
  output logic [D-1:0] o_reg_en,
  output logic         o_clr_sel,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_busy,
  output logic         o_err
);

  localparam int IDX_W = idx_w(D);

  share_load_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_at_last;
  logic              w_accept;
  logic              r_err;

  assign w_accept = (r_state == LOAD) && i_in_valid && i_rnd_valid;

  share_load_idx_cnt #(.D(D), .IDX_W(IDX_W)) u_idx (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc     (w_accept),
    .o_idx     (w_idx),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // idx is authoritative; a misplaced in_last only flags, never reframes
      if (w_accept && (i_in_last != w_at_last)) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_reg_en    = '0;
    case (r_state)
      IDLE: w_state_nxt = LOAD;
      LOAD: begin
        o_in_ready = i_rnd_valid;
        if (w_accept) begin
          o_reg_en = {{(D-1){1'b0}}, 1'b1} << w_idx;
          if (w_at_last) w_state_nxt = FULL;
        end
      end
      FULL: begin
`ifdef SHARE_LOAD_CLEAR_EN
        if (i_out_ready) w_state_nxt = CLEAR;
`else
        if (i_out_ready) w_state_nxt = LOAD;
`endif
      end
`ifdef SHARE_LOAD_CLEAR_EN
      CLEAR: begin
        o_reg_en    = '1;
        w_state_nxt = LOAD;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_out_valid = (r_state == FULL);
  assign o_err       = r_err;
  assign o_busy      = (r_state == FULL) || (r_state == CLEAR) ||
                       ((r_state == LOAD) && (w_idx != '0));
`ifdef SHARE_LOAD_CLEAR_EN
  assign o_clr_sel   = (r_state == CLEAR);
`else
  assign o_clr_sel   = 1'b0;
`endif

endmodule

// File: tb/tb_share_load_ctrl.sv
// Bench for share_load_ctrl: D=2 and D=3 instances on shared stimulus,
// vector table, corner sequences and random traffic against a share-count model.
module tb_share_load_ctrl;

`ifdef SHARE_LOAD_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic iv, il, rv, ordy;
  logic ir2, clr2, ov2, bs2, er2;
  logic ir3, clr3, ov3, bs3, er3;
  logic [1:0] en2;
  logic [2:0] en3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  share_load_ctrl #(.D(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(ir2), .i_in_last(il),
    .i_rnd_valid(rv), .o_reg_en(en2), .o_clr_sel(clr2), .o_out_valid(ov2),
    .i_out_ready(ordy), .o_busy(bs2), .o_err(er2));

  share_load_ctrl #(.D(3)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(ir3), .i_in_last(il),
    .i_rnd_valid(rv), .o_reg_en(en3), .o_clr_sel(clr3), .o_out_valid(ov3),
    .i_out_ready(ordy), .o_busy(bs3), .o_err(er3));

  // phase: 0 idle, 1 loading, 2 full, 3 clearing; n = shares already loaded
  typedef struct { int phase; int n; bit err; } mdl_t;
  mdl_t m2, m3;

  function automatic mdl_t mdl_step(mdl_t m, int d);
    mdl_t r = m;
    case (m.phase)
      0: r.phase = 1;
      1: if (iv && rv) begin
           if (il != (m.n == d - 1)) r.err = 1'b1;
           if (m.n == d - 1) begin r.n = 0; r.phase = 2; end
           else r.n = m.n + 1;
         end
      2: if (ordy) r.phase = CLR ? 3 : 1;
      default: r.phase = 1;
    endcase
    return r;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tg, input mdl_t m, input int d, input int ir,
                           input int en, input int clr, input int ov, input int bs, input int er);
    int e_en;
    e_en = 0;
    if (m.phase == 1 && iv && rv) e_en = 1 << m.n;
    if (m.phase == 3) e_en = (1 << d) - 1;
    cmp({tg, ".in_ready"},  ir,  int'(m.phase == 1 && rv));
    cmp({tg, ".reg_en"},    en,  e_en);
    cmp({tg, ".clr_sel"},   clr, int'(m.phase == 3));
    cmp({tg, ".out_valid"}, ov,  int'(m.phase == 2));
    cmp({tg, ".busy"},      bs,  int'(m.phase >= 2 || (m.phase == 1 && m.n != 0)));
    cmp({tg, ".err"},       er,  int'(m.err));
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic d);
    iv = a; il = b; rv = c; ordy = d;
    #1;
    chk_model("u2", m2, 2, ir2, en2, clr2, ov2, bs2, er2);
    chk_model("u3", m3, 3, ir3, en3, clr3, ov3, bs3, er3);
  endtask

  task automatic tick();
    @(posedge clk);
    m2 = mdl_step(m2, 2);
    m3 = mdl_step(m3, 3);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv = 0; il = 0; rv = 1; ordy = 0;
    #1;
    cmp("rst.u2.outs", {ir2, en2, clr2, ov2, bs2, er2}, 0);
    cmp("rst.u3.outs", {ir3, en3, clr3, ov3, bs3, er3}, 0);
    m2 = '{0, 0, 1'b0};
    m3 = '{0, 0, 1'b0};
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic iv, il, rv, ordy;
    logic ir; logic [1:0] en; logic ov; logic bs; logic er;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int acc;
    rst_n = 1'b0; iv = 0; il = 0; rv = 0; ordy = 0;
    // D=2 basic sharing: idle cycle, two accepts, full, consume
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0,  1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1,  1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].iv, tbl[i].il, tbl[i].rv, tbl[i].ordy);
      cmp($sformatf("tbl%0d.in_ready", i),  ir2, tbl[i].ir);
      cmp($sformatf("tbl%0d.reg_en", i),    en2, tbl[i].en);
      cmp($sformatf("tbl%0d.out_valid", i), ov2, tbl[i].ov);
      cmp($sformatf("tbl%0d.busy", i),      bs2, tbl[i].bs);
      cmp($sformatf("tbl%0d.err", i),       er2, tbl[i].er);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("post_consume.clr_sel", clr2, int'(CLR));
    cmp("post_consume.reg_en",  en2,  CLR ? 3 : 0);
    cmp("post_consume.in_ready", ir2, CLR ? 0 : 1);
    tick();
    if (CLR) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      cmp("after_clear.in_ready", ir2, 1);
      cmp("after_clear.busy", bs2, 0);
      tick();
    end

    // D=3 randomness stall: rnd_valid 1,0,0,1,1 with in_valid held
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    acc = 0;
    begin
      logic [4:0] pat;
      pat = 5'b11001;
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, acc == 2, pat[i], 1'b0);
        if (en3 != 0) acc++;
        if (!pat[i]) cmp("stall.reg_en", en3, 0);
        tick();
      end
    end
    cmp("stall.accepts", acc, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("stall.out_valid", ov3, 1);

    // FULL hold on u2 with in_valid pulses
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(i[0], 1'b0, 1'b1, 1'b0);
      cmp("hold.out_valid", ov2, 1);
      cmp("hold.in_ready",  ir2, 0);
      cmp("hold.reg_en",    en2, 0);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1); tick();

    // framing error: in_last on first share of D=2
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    cmp("frame.err_set", er2, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("frame.out_valid", ov2, 1);
    cmp("frame.err_sticky", er2, 1);
    tick();

    // reset mid-load on D=3 after one share
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("midrst.busy_before", bs3, 1);
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    cmp("midrst.idle_in_ready", ir3, 0);
    cmp("midrst.idle_reg_en", en3, 0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    cmp("midrst.restart_en", en3, 1);
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
